bp_be_stride_prefetch_gen: RTL and testbench
============================================

Name: bp_be_stride_prefetch_gen

Overview:
- Downstream consumer of the stride detector's discovery outputs.
- On a confirmed stride, walks the stream ahead of the demand load: emits up to depth_p line-aligned prefetch addresses (base + k*stride) over a valid/ready handshake toward the D$ prefetch port.
- Tracks one active stream. Suppresses duplicate lines and page crossings.
- Aborts or retargets the stream on new discovery events for the same PC.

Parameters:
- bp_params_p, e_bp_default_cfg, processor config (supplies vaddr_width_p).
- stride_width_p, 8, width of the signed stride input.
- effective_addr_width_p, vaddr_width_p, width of effective addresses.
- depth_p, 4, number of prefetch candidates generated per confirmation (>=1).
- line_offset_width_p, 6, log2 of cache line bytes (64B).
- page_offset_width_p, 12, log2 of page bytes (4KB); stream never crosses a page.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- start_discovery_i  in  1  detector saw a new or changed stride for striding_pc_i.
- confirm_discovery_i  in  1  detector confirmed a steady stride for striding_pc_i.
- striding_pc_i  in  vaddr_width_p  PC of the striding load.
- eff_addr_i  in  effective_addr_width_p  most recent effective address of that load.
- stride_i  in  stride_width_p  signed two's-complement stride in bytes.
- prefetch_v_o  out  1  prefetch request valid.
- prefetch_addr_o  out  effective_addr_width_p  line-aligned address (low line_offset_width_p bits zero).
- prefetch_ready_and_i  in  1  downstream accepts the request this cycle.
- busy_o  out  1  a stream is active (state ISSUE).
- dropped_o  out  1  one-cycle pulse: a confirmation was discarded because a different PC is active.

Behaviour:
- Reset: state IDLE. prefetch_v_o=0, prefetch_addr_o=0, busy_o=0, dropped_o=0. Active pc/addr/stride/count/last_line registers =0; last_line_v=0.
- Arithmetic:
  - stride_i is sign-extended to effective_addr_width_p.
  - Addition is modulo 2^effective_addr_width_p.
  - line(a) = a with the low line_offset_width_p bits cleared.
  - page(a) = a >> page_offset_width_p.
- IDLE:
  - A confirmation is confirm_discovery_i=1 with stride_i!=0.
  - On a confirmation, next cycle: ISSUE, cur_addr=eff_addr_i+stride, base_page=page(eff_addr_i), count=depth_p, pc=striding_pc_i, stride captured.
  - confirm_discovery_i with stride_i==0 is ignored.
  - start_discovery_i is ignored in IDLE.
- ISSUE, per cycle, in priority order:
  1. Abort: start_discovery_i=1 and striding_pc_i==pc. Go IDLE next cycle; any pending request is withdrawn; last_line_v cleared.
  2. Retarget: confirm_discovery_i=1, stride_i!=0, striding_pc_i==pc. Reload exactly as from IDLE; stay ISSUE. A same-cycle handshake is still counted as accepted downstream, but the reload wins.
  3. Drop: confirm_discovery_i=1 and striding_pc_i!=pc. Pulse dropped_o next cycle; the stream continues unaffected.
  4. Page stop: page(cur_addr)!=base_page. Go IDLE; no request issued.
  5. Duplicate skip: last_line_v && line(cur_addr)==last_line. prefetch_v_o=0; cur_addr+=stride and count-=1 in the same cycle.
  6. Otherwise: prefetch_v_o=1, prefetch_addr_o=line(cur_addr). On prefetch_ready_and_i: last_line=line(cur_addr), last_line_v=1, cur_addr+=stride, count-=1.
- After count reaches 0: IDLE.
- prefetch_v_o and prefetch_addr_o are combinational from registered state (zero-cycle decision, registers update at the edge).
  - Latency: confirmation at cycle N gives the first valid at N+1.
  - With ready held high: one request per cycle, except skipped lines.
- Valid/ready: once asserted, prefetch_v_o and prefetch_addr_o hold stable until handshake. Sole exceptions are abort and retarget, which may withdraw or change the request (prefetches are droppable).
- busy_o = (state==ISSUE).
- Reset asserted mid-stream: returns to IDLE at the next edge; no request survives.
- Negative strides walk downward. Wrap past address 0 is legal arithmetic but is caught by the page stop.

Test Plan:
- Basic stream: confirm pc=0x80001000, eff_addr=0x1000, stride=0x40, ready=1 → 0x1040, 0x1080, 0x10C0, 0x1100 on 4 consecutive cycles; then busy_o=0.
- Small stride, duplicate suppression: confirm eff_addr=0x2000, stride=0x08, ready=1 → single request 0x2000; the next 3 candidates are skipped; stream ends 4 cycles after start.
- Backpressure: stride=0x40, ready low for 3 cycles → 0x1040 held stable with valid=1 throughout; the sequence resumes unchanged after ready rises.
- Page stop and negative stride: eff_addr=0x1FC0, stride=0x40 → no request (0x2000 is in a new page), IDLE. eff_addr=0x1100, stride=-0x40 (0xC0) → 0x10C0, 0x1080, 0x1040, 0x1000.
- Same-PC events: retarget mid-stream to eff_addr=0x3000 → next request 0x3040, count restarts at 4. start_discovery for the active pc → valid drops next cycle, IDLE.
- Drop and reset: confirm for another pc while active → dropped_o pulses one cycle, the original sequence is unchanged. reset_i asserted mid-stream → all outputs 0 next cycle.

Source files
------------

// File: rtl/bp_be_stride_prefetch_gen.sv
// Stride prefetch generator: on a confirmed stride, walks up to depth_p line-aligned
// addresses ahead of the demand load within one page, over a valid/ready handshake.
module bp_be_stride_prefetch_gen #(
    parameter int vaddr_width_p          = 39,
    parameter int stride_width_p         = 8,
    parameter int effective_addr_width_p = vaddr_width_p,
    parameter int depth_p                = 4,
    parameter int line_offset_width_p    = 6,
    parameter int page_offset_width_p    = 12
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              start_discovery_i,
    input  logic                              confirm_discovery_i,
    input  logic [vaddr_width_p-1:0]          striding_pc_i,
    input  logic [effective_addr_width_p-1:0] eff_addr_i,
    input  logic [stride_width_p-1:0]         stride_i,
    output logic                              prefetch_v_o,
    output logic [effective_addr_width_p-1:0] prefetch_addr_o,
    input  logic                              prefetch_ready_and_i,
    output logic                              busy_o,
    output logic                              dropped_o
);

    localparam int ea_w_lp    = effective_addr_width_p;
    localparam int count_w_lp = $clog2(depth_p + 1);
    localparam int page_w_lp  = ea_w_lp - page_offset_width_p;
    localparam logic [ea_w_lp-1:0] line_mask_lp =
        {{(ea_w_lp - line_offset_width_p){1'b1}}, {line_offset_width_p{1'b0}}};

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [vaddr_width_p-1:0] pc_q, pc_d;
    logic [ea_w_lp-1:0]       cur_addr_q, cur_addr_d;
    logic [ea_w_lp-1:0]       stride_q, stride_d;
    logic [page_w_lp-1:0]     base_page_q, base_page_d;
    logic [count_w_lp-1:0]    count_q, count_d;
    logic [ea_w_lp-1:0]       last_line_q, last_line_d;
    logic                     last_line_v_q, last_line_v_d;
    logic                     dropped_q, dropped_d;

    logic [ea_w_lp-1:0] stride_ext;
    logic [ea_w_lp-1:0] cur_line;
    logic               page_stop;
    logic               dup_skip;
    logic               issue_v;
    logic               is_confirm;
    logic               same_pc;

    assign stride_ext = {{(ea_w_lp - stride_width_p){stride_i[stride_width_p-1]}}, stride_i};
    assign cur_line   = cur_addr_q & line_mask_lp;
    assign page_stop  = (cur_addr_q[ea_w_lp-1:page_offset_width_p] != base_page_q);
    assign dup_skip   = last_line_v_q && (cur_line == last_line_q);
    assign is_confirm = confirm_discovery_i && (stride_i != '0);
    assign same_pc    = (striding_pc_i == pc_q);

    // The request depends only on registered state, so it stays stable under backpressure.
    assign issue_v         = (state_q == ISSUE) && !page_stop && !dup_skip;
    assign prefetch_v_o    = issue_v;
    assign prefetch_addr_o = issue_v ? cur_line : '0;
    assign busy_o          = (state_q == ISSUE);
    assign dropped_o       = dropped_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        cur_addr_d    = cur_addr_q;
        stride_d      = stride_q;
        base_page_d   = base_page_q;
        count_d       = count_q;
        last_line_d   = last_line_q;
        last_line_v_d = last_line_v_q;
        dropped_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (is_confirm) begin
                    state_d     = ISSUE;
                    cur_addr_d  = eff_addr_i + stride_ext;
                    base_page_d = eff_addr_i[ea_w_lp-1:page_offset_width_p];
                    count_d     = count_w_lp'(depth_p);
                    pc_d        = striding_pc_i;
                    stride_d    = stride_ext;
                end
            end
            ISSUE: begin
                if (start_discovery_i && same_pc) begin
                    state_d       = IDLE;
                    last_line_v_d = 1'b0;
                end else if (is_confirm && same_pc) begin
                    // The accepted line is still recorded; the stream position is reloaded.
                    if (issue_v && prefetch_ready_and_i) begin
                        last_line_d   = cur_line;
                        last_line_v_d = 1'b1;
                    end
                    cur_addr_d  = eff_addr_i + stride_ext;
                    base_page_d = eff_addr_i[ea_w_lp-1:page_offset_width_p];
                    count_d     = count_w_lp'(depth_p);
                    stride_d    = stride_ext;
                end else begin
                    if (confirm_discovery_i && !same_pc) begin
                        dropped_d = 1'b1;
                    end
                    if (page_stop) begin
                        state_d = IDLE;
                    end else if (dup_skip || prefetch_ready_and_i) begin
                        if (!dup_skip) begin
                            last_line_d   = cur_line;
                            last_line_v_d = 1'b1;
                        end
                        cur_addr_d = cur_addr_q + stride_q;
                        count_d    = count_q - 1'b1;
                        if (count_q == count_w_lp'(1)) begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            cur_addr_q    <= '0;
            stride_q      <= '0;
            base_page_q   <= '0;
            count_q       <= '0;
            last_line_q   <= '0;
            last_line_v_q <= 1'b0;
            dropped_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            cur_addr_q    <= cur_addr_d;
            stride_q      <= stride_d;
            base_page_q   <= base_page_d;
            count_q       <= count_d;
            last_line_q   <= last_line_d;
            last_line_v_q <= last_line_v_d;
            dropped_q     <= dropped_d;
        end
    end

endmodule

// File: tb/tb_bp_be_stride_prefetch_gen.sv
// Directed bench for bp_be_stride_prefetch_gen: expected prefetch addresses are queued
// when a confirmation is driven and popped as each request is accepted.
module tb_bp_be_stride_prefetch_gen;

    localparam int VA = 39;
    localparam int EA = 39;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          start_discovery_i;
    logic          confirm_discovery_i;
    logic [VA-1:0] striding_pc_i;
    logic [EA-1:0] eff_addr_i;
    logic [SW-1:0] stride_i;
    logic          prefetch_v_o;
    logic [EA-1:0] prefetch_addr_o;
    logic          prefetch_ready_and_i;
    logic          busy_o;
    logic          dropped_o;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [EA-1:0] sb_q[$];

    localparam logic [VA-1:0] PC_A = 39'h80001000;
    localparam logic [VA-1:0] PC_B = 39'h80002000;

    bp_be_stride_prefetch_gen #(
        .vaddr_width_p         (VA),
        .stride_width_p        (SW),
        .effective_addr_width_p(EA),
        .depth_p               (4),
        .line_offset_width_p   (6),
        .page_offset_width_p   (12)
    ) dut (
        .clk_i               (clk),
        .reset_i             (reset_i),
        .start_discovery_i   (start_discovery_i),
        .confirm_discovery_i (confirm_discovery_i),
        .striding_pc_i       (striding_pc_i),
        .eff_addr_i          (eff_addr_i),
        .stride_i            (stride_i),
        .prefetch_v_o        (prefetch_v_o),
        .prefetch_addr_o     (prefetch_addr_o),
        .prefetch_ready_and_i(prefetch_ready_and_i),
        .busy_o              (busy_o),
        .dropped_o           (dropped_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Checks the request currently presented against the scoreboard head.
    task automatic expect_req(input string tag);
        logic [EA-1:0] exp;
        chk({tag, "_v"}, 64'(prefetch_v_o), 64'd1);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_underflow"}, 64'(prefetch_addr_o), 64'hDEAD);
        end else begin
            exp = sb_q.pop_front();
            chk({tag, "_addr"}, 64'(prefetch_addr_o), 64'(exp));
        end
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        cycle();
        reset_i = 1'b0;
    endtask

    task automatic confirm(input logic [VA-1:0] pc, input logic [EA-1:0] ea, input logic [SW-1:0] st);
        confirm_discovery_i = 1'b1;
        striding_pc_i       = pc;
        eff_addr_i          = ea;
        stride_i            = st;
        cycle();
        confirm_discovery_i = 1'b0;
    endtask

    task automatic push4(input logic [EA-1:0] a0, input logic [EA-1:0] a1,
                         input logic [EA-1:0] a2, input logic [EA-1:0] a3);
        sb_q.push_back(a0);
        sb_q.push_back(a1);
        sb_q.push_back(a2);
        sb_q.push_back(a3);
    endtask

    initial begin
        reset_i              = 1'b1;
        start_discovery_i    = 1'b0;
        confirm_discovery_i  = 1'b0;
        striding_pc_i        = '0;
        eff_addr_i           = '0;
        stride_i             = '0;
        prefetch_ready_and_i = 1'b0;
        repeat (2) cycle();
        chk("rst_v", 64'(prefetch_v_o), 64'd0);
        chk("rst_addr", 64'(prefetch_addr_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_dropped", 64'(dropped_o), 64'd0);
        reset_i = 1'b0;

        // Zero-stride confirm and start in IDLE are both ignored.
        confirm(PC_A, 39'h1000, 8'h00);
        chk("zero_stride_busy", 64'(busy_o), 64'd0);
        start_discovery_i = 1'b1;
        striding_pc_i     = PC_A;
        cycle();
        start_discovery_i = 1'b0;
        chk("idle_start_busy", 64'(busy_o), 64'd0);

        // Basic stream
        do_reset();
        prefetch_ready_and_i = 1'b1;
        push4(39'h1040, 39'h1080, 39'h10C0, 39'h1100);
        confirm(PC_A, 39'h1000, 8'h40);
        for (int i = 0; i < 4; i++) begin
            expect_req("basic");
            cycle();
        end
        chk("basic_end_busy", 64'(busy_o), 64'd0);
        chk("basic_end_v", 64'(prefetch_v_o), 64'd0);

        // Duplicate suppression
        do_reset();
        sb_q.push_back(39'h2000);
        confirm(PC_A, 39'h2000, 8'h08);
        expect_req("dup");
        cycle();
        for (int i = 0; i < 3; i++) begin
            chk("dup_skip_v", 64'(prefetch_v_o), 64'd0);
            chk("dup_skip_busy", 64'(busy_o), 64'd1);
            cycle();
        end
        chk("dup_end_busy", 64'(busy_o), 64'd0);

        // Backpressure
        do_reset();
        prefetch_ready_and_i = 1'b0;
        push4(39'h1040, 39'h1080, 39'h10C0, 39'h1100);
        confirm(PC_A, 39'h1000, 8'h40);
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_v", 64'(prefetch_v_o), 64'd1);
            chk("bp_hold_addr", 64'(prefetch_addr_o), 64'h1040);
            cycle();
        end
        prefetch_ready_and_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_req("bp");
            cycle();
        end
        chk("bp_end_busy", 64'(busy_o), 64'd0);

        // Page stop
        do_reset();
        confirm(PC_A, 39'h1FC0, 8'h40);
        chk("page_v", 64'(prefetch_v_o), 64'd0);
        chk("page_busy1", 64'(busy_o), 64'd1);
        cycle();
        chk("page_busy2", 64'(busy_o), 64'd0);
        chk("page_v2", 64'(prefetch_v_o), 64'd0);

        // Negative stride
        do_reset();
        push4(39'h10C0, 39'h1080, 39'h1040, 39'h1000);
        confirm(PC_A, 39'h1100, 8'hC0);
        for (int i = 0; i < 4; i++) begin
            expect_req("neg");
            cycle();
        end
        chk("neg_end_busy", 64'(busy_o), 64'd0);

        // Retarget mid-stream, with a same-cycle handshake
        do_reset();
        sb_q.push_back(39'h1040);
        confirm(PC_A, 39'h1000, 8'h40);
        expect_req("rt_pre");
        cycle();
        chk("rt_cur_addr", 64'(prefetch_addr_o), 64'h1080);
        push4(39'h3040, 39'h3080, 39'h30C0, 39'h3100);
        confirm(PC_A, 39'h3000, 8'h40);
        for (int i = 0; i < 4; i++) begin
            chk("rt_busy", 64'(busy_o), 64'd1);
            expect_req("rt");
            cycle();
        end
        chk("rt_end_busy", 64'(busy_o), 64'd0);

        // Abort by start_discovery for the active PC
        do_reset();
        sb_q.push_back(39'h1040);
        confirm(PC_A, 39'h1000, 8'h40);
        expect_req("ab_pre");
        cycle();
        chk("ab_v_before", 64'(prefetch_v_o), 64'd1);
        start_discovery_i = 1'b1;
        striding_pc_i     = PC_A;
        cycle();
        start_discovery_i = 1'b0;
        chk("ab_v", 64'(prefetch_v_o), 64'd0);
        chk("ab_busy", 64'(busy_o), 64'd0);

        // Drop: confirmation from another PC while active
        do_reset();
        push4(39'h1040, 39'h1080, 39'h10C0, 39'h1100);
        confirm(PC_A, 39'h1000, 8'h40);
        chk("drop_pre", 64'(dropped_o), 64'd0);
        expect_req("drop");
        confirm(PC_B, 39'h5000, 8'h10);
        chk("drop_pulse", 64'(dropped_o), 64'd1);
        expect_req("drop");
        cycle();
        chk("drop_clear", 64'(dropped_o), 64'd0);
        expect_req("drop");
        start_discovery_i = 1'b1;
        striding_pc_i     = PC_B;
        cycle();
        start_discovery_i = 1'b0;
        chk("drop_other_start_busy", 64'(busy_o), 64'd1);
        expect_req("drop");
        cycle();
        chk("drop_end_busy", 64'(busy_o), 64'd0);

        // Reset mid-stream
        do_reset();
        sb_q.push_back(39'h1040);
        confirm(PC_A, 39'h1000, 8'h40);
        expect_req("mr");
        cycle();
        chk("mr_busy_before", 64'(busy_o), 64'd1);
        do_reset();
        chk("mr_v", 64'(prefetch_v_o), 64'd0);
        chk("mr_addr", 64'(prefetch_addr_o), 64'd0);
        chk("mr_busy", 64'(busy_o), 64'd0);
        chk("mr_dropped", 64'(dropped_o), 64'd0);
        cycle();
        chk("mr_idle_v", 64'(prefetch_v_o), 64'd0);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
